dmem_dump_streamer: RTL and testbench

//  Reads data memory back out of the 16-bit pipeline processor after a run, one word per handshake.

---
 rtl/dmem_dump_streamer_pkg.sv | 15 +
 rtl/dmem_dump_streamer_if.sv | 25 ++
 rtl/dmem_dump_streamer_out_reg.sv | 32 +++
 rtl/dmem_dump_streamer.sv | 122 ++++++++++++
 tb/tb_dmem_dump_streamer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_dump_streamer_pkg.sv
// rtl/dmem_dump_streamer_pkg.sv - shared widths and sequencer state encodings for the dmem dump streamer
package dmem_dump_streamer_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/dmem_dump_streamer_if.sv
// rtl/dmem_dump_streamer_if.sv - dmem read port plus {addr,data} beat stream
interface dmem_dump_streamer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output mem_re, mem_addr, out_valid, out_addr, out_data,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_re, mem_addr, out_valid, out_addr, out_data,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/dmem_dump_streamer_out_reg.sv
// rtl/dmem_dump_streamer_out_reg.sv - holding register for the outgoing beat
module dump_out_reg #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // clear only drops valid; addr/data keep the last beat
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_dump_streamer.sv
// rtl/dmem_dump_streamer.sv - walks a dmem address range and streams {addr,data} beats
module dmem_dump_streamer
  import dmem_dump_streamer_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       count,
  dmem_dump_streamer_if.master  bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REMAIN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W:0]   count_sat;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic              load;
  logic              handshake;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  // the sequencer is built around a single-cycle read; RD_LAT only documents that
  wire unused_rd_lat = (RD_LAT == 1);

  assign count_sat = (count > MAX_COUNT) ? MAX_COUNT : count;
  assign load      = (state == S_WAIT);
  assign handshake = (state == S_PRESENT) && bus.out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cur      <= '0;
      remain   <= '0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cur    <= base_addr;
            remain <= count_sat;
            done   <= 1'b0;
            if (count_sat == '0) begin
              // empty dump: done drops for one cycle, then re-asserts from S_DONE
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              state    <= S_READ;
              busy     <= 1'b1;
              mem_re   <= 1'b1;
              mem_addr <= base_addr;
            end
          end else if (state == S_DONE) begin
            done <= 1'b1;
          end
        end
        S_READ: begin
          mem_re <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (handshake) begin
            cur    <= cur + ADDR_ONE;
            remain <= remain - REMAIN_ONE;
            if (remain == REMAIN_ONE) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= S_READ;
              mem_re   <= 1'b1;
              mem_addr <= cur + ADDR_ONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  dump_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .clear     (handshake),
    .load_addr (cur),
    .load_data (bus.mem_rdata),
    .valid     (out_valid),
    .addr      (out_addr),
    .data      (out_data)
  );

  assign bus.mem_re    = mem_re;
  assign bus.mem_addr  = mem_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// tb/tb_dmem_dump_streamer.sv - scoreboard bench for the dmem dump streamer
module tb_dmem_dump_streamer;
  import dmem_dump_streamer_pkg::*;

  localparam int AW = DMEM_ADDR_W;
  localparam int DW = DMEM_DATA_W;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int beats = 0;
  int re_pulses = 0;

  logic [DW-1:0]    mem [256];
  logic [DW-1:0]    rdata_q;
  logic [AW+DW-1:0] sb [$];

  dmem_dump_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_dump_streamer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 256; i++) mem[i] = DW'(16'hA500 ^ i);

  always @(posedge clock) if (bus.mem_re) rdata_q <= mem[bus.mem_addr];
  assign bus.mem_rdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("busy_done_exclusive", 32'(busy & done), 32'd0);
      if (bus.mem_re) re_pulses++;
      if (bus.out_valid && bus.out_ready) begin
        logic [AW+DW-1:0] exp;
        beats++;
        exp = (sb.size() > 0) ? sb.pop_front() : {(AW+DW){1'bx}};
        chk("beat_addr", 32'(bus.out_addr), 32'(exp[AW+DW-1:DW]));
        chk("beat_data", 32'(bus.out_data), 32'(exp[DW-1:0]));
        chk("beat_model", 32'(bus.out_data), 32'(mem[bus.out_addr]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c, input bit accept);
    int n;
    logic [AW-1:0] a;
    start = 1'b1;
    base_addr = b;
    count = c;
    if (accept) begin
      n = (c > 256) ? 256 : int'(c);
      for (int i = 0; i < n; i++) begin
        a = b + AW'(i);
        sb.push_back({a, mem[a]});
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      step();
      n++;
    end
    chk("valid_reached", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic clear_counts();
    beats = 0;
    re_pulses = 0;
  endtask

  initial begin
    int lat;
    bit stable;
    int re_snap;
    logic [AW-1:0] a_snap;
    logic [DW-1:0] d_snap;

    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (2) step();
    chk("idle_busy", 32'(busy), 32'd0);

    // full sweep, with first-beat latency
    clear_counts();
    do_start(8'h00, 9'd256, 1'b1);
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("first_valid_latency", 32'(lat), 32'd3);
    wait_done(2000);
    chk("t1_beats", 32'(beats), 32'd256);
    chk("t1_re_pulses", 32'(re_pulses), 32'd256);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // wrap across the top of the address space
    clear_counts();
    do_start(8'hF0, 9'd32, 1'b1);
    wait_done(400);
    chk("t2_beats", 32'(beats), 32'd32);
    chk("t2_re_pulses", 32'(re_pulses), 32'd32);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // backpressure: 10 stalled cycles per beat
    clear_counts();
    bus.out_ready = 1'b0;
    do_start(8'h10, 9'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_valid(20);
      a_snap = bus.out_addr;
      d_snap = bus.out_data;
      re_snap = re_pulses;
      stable = 1'b1;
      for (int j = 0; j < 10; j++) begin
        step();
        if (!bus.out_valid || bus.out_addr !== a_snap || bus.out_data !== d_snap) stable = 1'b0;
      end
      chk("t3_stall_stable", 32'(stable), 32'd1);
      chk("t3_stall_no_reads", 32'(re_pulses), 32'(re_snap));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    bus.out_ready = 1'b1;
    wait_done(50);
    chk("t3_beats", 32'(beats), 32'd4);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // empty dump, then a start issued mid-dump
    clear_counts();
    do_start(8'h33, 9'd0, 1'b1);
    repeat (4) step();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_reads", 32'(re_pulses), 32'd0);
    chk("t4_no_beats", 32'(beats), 32'd0);
    do_start(8'h20, 9'd8, 1'b1);
    repeat (4) step();
    chk("t4_busy_mid", 32'(busy), 32'd1);
    do_start(8'h80, 9'd3, 1'b0);
    wait_done(100);
    chk("t4_beats", 32'(beats), 32'd8);
    chk("t4_re_pulses", 32'(re_pulses), 32'd8);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // reset during beat 5 of 16
    clear_counts();
    do_start(8'h40, 9'd16, 1'b1);
    lat = 0;
    while (!(bus.out_valid && beats == 4) && lat < 100) begin
      step();
      lat++;
    end
    chk("t5_at_beat5", 32'(beats), 32'd4);
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    sb.delete();
    repeat (2) step();
    reset = 1'b1;
    step();
    clear_counts();
    do_start(8'h00, 9'd2, 1'b1);
    wait_done(50);
    chk("t5_beats", 32'(beats), 32'd2);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
